// File: rtl/prga_enc.sv
// RC4 PRGA encryptor: ct[0]=L, ct[k] = pt[k] ^ keystream over an S array already scheduled by KSA.
// Latency: 3 + 11*L cycles from en acceptance to rdy=1 (each S/pt read spends one address and one data cycle).
// Backpressure: none downstream; en is taken only while rdy=1 and ignored while busy or in reset.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en / rdy            start request / idle-and-ready
//   s_addr, s_rddata, s_wrdata, s_wren     S array port (1-cycle read latency)
//   pt_addr, pt_rddata                      plaintext port (1-cycle read latency)
//   ct_addr, ct_wrdata, ct_wren             ciphertext write port
module prga_enc (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata,
  output logic [7:0] ct_addr,
  output logic [7:0] ct_wrdata,
  output logic       ct_wren
);

  typedef enum logic [3:0] {
    IDLE, RD_LEN, WR_LEN, RD_SI, RD_SJ, WR_SI, WR_SJ, RD_PAD, RD_PT, WR_CT, DONE
  } state_t;

  state_t     state;
  logic       phase;    // read states: 0 = address on bus, 1 = data valid
  logic [7:0] i;
  logic [7:0] j;
  logic [7:0] k;
  logic [7:0] msg_len;
  logic [7:0] si;       // pre-swap s[i]
  logic [7:0] sj;       // pre-swap s[j]
  logic [7:0] pad;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= 1'b0;
      rdy       <= 1'b1;
      s_addr    <= 8'd0;
      s_wrdata  <= 8'd0;
      s_wren    <= 1'b0;
      pt_addr   <= 8'd0;
      ct_addr   <= 8'd0;
      ct_wrdata <= 8'd0;
      ct_wren   <= 1'b0;
      i         <= 8'd0;
      j         <= 8'd0;
      k         <= 8'd0;
      msg_len   <= 8'd0;
      si        <= 8'd0;
      sj        <= 8'd0;
      pad       <= 8'd0;
    end else begin
      case (state)
        // pt_addr is parked at 0 while idle, so pt[0] is already being read
        // on the acceptance edge and arrives during RD_LEN.
        IDLE: begin
          if (en) begin
            rdy   <= 1'b0;
            i     <= 8'd0;
            j     <= 8'd0;
            k     <= 8'd0;
            phase <= 1'b0;
            state <= RD_LEN;
          end
        end
        RD_LEN: begin
          msg_len   <= pt_rddata;
          ct_addr   <= 8'd0;
          ct_wrdata <= pt_rddata;
          ct_wren   <= 1'b1;
          state     <= WR_LEN;
        end
        WR_LEN: begin
          ct_wren <= 1'b0;
          if (msg_len == 8'd0) begin
            state <= DONE;
          end else begin
            i      <= i + 8'd1;
            s_addr <= i + 8'd1;
            k      <= 8'd1;
            state  <= RD_SI;
          end
        end
        RD_SI: begin
          if (!phase) begin
            phase <= 1'b1;
          end else begin
            phase  <= 1'b0;
            si     <= s_rddata;
            j      <= j + s_rddata;
            s_addr <= j + s_rddata;
            state  <= RD_SJ;
          end
        end
        RD_SJ: begin
          if (!phase) begin
            phase <= 1'b1;
          end else begin
            phase    <= 1'b0;
            sj       <= s_rddata;
            s_addr   <= i;
            s_wrdata <= s_rddata;
            s_wren   <= 1'b1;
            state    <= WR_SI;
          end
        end
        // When i == j both writes hit the same address with the same value.
        WR_SI: begin
          s_addr   <= j;
          s_wrdata <= si;
          state    <= WR_SJ;
        end
        WR_SJ: begin
          s_wren <= 1'b0;
          s_addr <= si + sj;    // pad index from the pre-swap values
          state  <= RD_PAD;
        end
        RD_PAD: begin
          if (!phase) begin
            phase <= 1'b1;
          end else begin
            phase   <= 1'b0;
            pad     <= s_rddata;
            pt_addr <= k;
            state   <= RD_PT;
          end
        end
        RD_PT: begin
          if (!phase) begin
            phase <= 1'b1;
          end else begin
            phase     <= 1'b0;
            ct_addr   <= k;
            ct_wrdata <= pad ^ pt_rddata;
            ct_wren   <= 1'b1;
            state     <= WR_CT;
          end
        end
        // k is compared before incrementing, so L=255 never wraps k.
        WR_CT: begin
          ct_wren <= 1'b0;
          if (k == msg_len) begin
            state <= DONE;
          end else begin
            i      <= i + 8'd1;
            s_addr <= i + 8'd1;
            k      <= k + 8'd1;
            state  <= RD_SI;
          end
        end
        DONE: begin
          rdy     <= 1'b1;
          pt_addr <= 8'd0;
          state   <= IDLE;
        end
        default: begin
          rdy   <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prga_enc.sv
// Self-checking bench for prga_enc: memory models for S/pt/ct plus an RC4 reference model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_prga_enc;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       rdy;
  logic [7:0] s_addr;
  logic [7:0] s_rddata;
  logic [7:0] s_wrdata;
  logic       s_wren;
  logic [7:0] pt_addr;
  logic [7:0] pt_rddata;
  logic [7:0] ct_addr;
  logic [7:0] ct_wrdata;
  logic       ct_wren;

  always #5 clk = ~clk;

  prga_enc dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .rdy       (rdy),
    .s_addr    (s_addr),
    .s_rddata  (s_rddata),
    .s_wrdata  (s_wrdata),
    .s_wren    (s_wren),
    .pt_addr   (pt_addr),
    .pt_rddata (pt_rddata),
    .ct_addr   (ct_addr),
    .ct_wrdata (ct_wrdata),
    .ct_wren   (ct_wren)
  );

  logic [7:0] s_mem  [256];
  logic [7:0] s_init [256];
  logic [7:0] pt_mem [256];
  logic [7:0] ct_mem [256];
  logic [7:0] exp_s  [256];
  logic [7:0] exp_ct [256];
  logic       ld_s;
  logic       clr;
  int         s_cnt;
  int         ct_cnt;
  int         checks   = 0;
  int         failures = 0;

  // synchronous-read memories; S reload and ct/counter clear happen only while the DUT is idle
  always @(posedge clk) begin
    s_rddata  <= s_mem[s_addr];
    pt_rddata <= pt_mem[pt_addr];
    if (ld_s) begin
      for (int x = 0; x < 256; x++) s_mem[x] <= s_init[x];
    end else if (s_wren) begin
      s_mem[s_addr] <= s_wrdata;
    end
    if (clr) begin
      for (int x = 0; x < 256; x++) ct_mem[x] <= 8'h00;
      s_cnt  <= 0;
      ct_cnt <= 0;
    end else begin
      if (ct_wren) begin
        ct_mem[ct_addr] <= ct_wrdata;
        ct_cnt <= ct_cnt + 1;
      end
      if (s_wren) s_cnt <= s_cnt + 1;
    end
  end

  task automatic chk_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_identity();
    for (int x = 0; x < 256; x++) begin
      s_init[x] = 8'(x);
      exp_s[x]  = 8'(x);
    end
  endtask

  task automatic set_perm();
    logic [7:0] t;
    int r;
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    for (int x = 255; x > 0; x--) begin
      r = $urandom_range(x, 0);
      t = s_init[x];
      s_init[x] = s_init[r];
      s_init[r] = t;
    end
    for (int x = 0; x < 256; x++) exp_s[x] = s_init[x];
  endtask

  task automatic set_pt(input int len);
    pt_mem[0] = 8'(len);
    for (int x = 1; x <= len; x++) pt_mem[x] = 8'($urandom_range(255, 0));
  endtask

  task automatic prep(input bit load_s);
    @(negedge clk);
    ld_s = load_s;
    clr  = 1'b1;
    @(posedge clk);
    #1;
    ld_s = 1'b0;
    clr  = 1'b0;
  endtask

  // textbook RC4 PRGA applied to exp_s / pt_mem
  task automatic model_run();
    int len, i, j;
    logic [7:0] t;
    len = pt_mem[0];
    i = 0;
    j = 0;
    exp_ct[0] = pt_mem[0];
    for (int k = 1; k <= len; k++) begin
      i = (i + 1) % 256;
      j = (j + exp_s[i]) % 256;
      t = exp_s[i];
      exp_s[i] = exp_s[j];
      exp_s[j] = t;
      exp_ct[k] = pt_mem[k] ^ exp_s[(exp_s[i] + exp_s[j]) % 256];
    end
  endtask

  task automatic start_and_wait(input string tag, input int len, output int n);
    @(negedge clk);
    chk_eq({tag, "_rdy_idle"}, int'(rdy), 1);
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    @(negedge clk);
    chk_eq({tag, "_rdy_drop"}, int'(rdy), 0);
    n = 0;
    while (!rdy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk_eq({tag, "_latency_ok"}, int'(n <= 4 + 12 * len), 1);
  endtask

  task automatic compare_all(input string tag, input int len, input int n_ct, input int n_s);
    int bad_ct, bad_s;
    bad_ct = 0;
    bad_s  = 0;
    for (int x = 0; x <= len; x++) if (ct_mem[x] !== exp_ct[x]) bad_ct++;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== exp_s[x]) bad_s++;
    chk_eq({tag, "_ct_bad_bytes"}, bad_ct, 0);
    chk_eq({tag, "_s_bad_bytes"}, bad_s, 0);
    chk_eq({tag, "_ct_wren_pulses"}, ct_cnt, n_ct);
    chk_eq({tag, "_s_wren_pulses"}, s_cnt, n_s);
  endtask

  task automatic load_basic_pt();
    pt_mem[0] = 8'h03;
    pt_mem[1] = 8'h41;
    pt_mem[2] = 8'h42;
    pt_mem[3] = 8'h43;
  endtask

  task automatic check_basic_ct(input string tag);
    chk_eq({tag, "_ct0"}, int'(ct_mem[0]), 'h03);
    chk_eq({tag, "_ct1"}, int'(ct_mem[1]), 'h43);
    chk_eq({tag, "_ct2"}, int'(ct_mem[2]), 'h47);
    chk_eq({tag, "_ct3"}, int'(ct_mem[3]), 'h44);
  endtask

  task automatic wait_rdy(input logic val, input string tag);
    int n;
    n = 0;
    while (rdy !== val && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk_eq({tag, "_rdy_reached"}, int'(rdy), int'(val));
  endtask

  initial begin
    int n, len, sv_s, sv_ct;
    rst  = 1'b1;
    en   = 1'b1;   // en during reset must be ignored
    ld_s = 1'b0;
    clr  = 1'b0;
    for (int x = 0; x < 256; x++) pt_mem[x] = 8'h00;
    set_identity();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_rdy", int'(rdy), 1);
    chk_eq("rst_s_wren", int'(s_wren), 0);
    chk_eq("rst_ct_wren", int'(ct_wren), 0);
    chk_eq("rst_outs_or", int'(s_addr | s_wrdata | pt_addr | ct_addr | ct_wrdata), 0);
    rst = 1'b0;
    en  = 1'b0;
    @(negedge clk);
    chk_eq("post_rst_rdy", int'(rdy), 1);

    // known-answer run on identity S
    set_identity();
    load_basic_pt();
    prep(1'b1);
    model_run();
    start_and_wait("basic", 3, n);
    chk_eq("basic_within_40", int'(n <= 40), 1);
    check_basic_ct("basic");
    chk_eq("basic_s2", int'(s_mem[2]), 'h03);
    chk_eq("basic_s3", int'(s_mem[3]), 'h05);
    chk_eq("basic_s5", int'(s_mem[5]), 'h02);
    compare_all("basic", 3, 4, 6);

    // second run continues on the permuted S, i and j restart at 0
    prep(1'b0);
    model_run();
    start_and_wait("b2b", 3, n);
    compare_all("b2b", 3, 4, 6);

    // empty message
    set_identity();
    pt_mem[0] = 8'h00;
    prep(1'b1);
    model_run();
    start_and_wait("len0", 0, n);
    chk_eq("len0_within_4", int'(n <= 4), 1);
    chk_eq("len0_ct0", int'(ct_mem[0]), 0);
    compare_all("len0", 0, 1, 0);

    // reset in the middle of the second byte
    set_identity();
    load_basic_pt();
    prep(1'b1);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    n = 0;
    while (ct_cnt < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk_eq("abort_reached_byte2", ct_cnt, 2);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_eq("abort_rdy", int'(rdy), 1);
    chk_eq("abort_s_wren", int'(s_wren), 0);
    chk_eq("abort_ct_wren", int'(ct_wren), 0);
    rst = 1'b0;
    sv_s  = s_cnt;
    sv_ct = ct_cnt;
    repeat (20) @(negedge clk);
    chk_eq("abort_no_s_writes", s_cnt, sv_s);
    chk_eq("abort_no_ct_writes", ct_cnt, sv_ct);
    chk_eq("abort_still_idle", int'(rdy), 1);
    set_identity();
    prep(1'b1);
    model_run();
    start_and_wait("rerun", 3, n);
    check_basic_ct("rerun");
    compare_all("rerun", 3, 4, 6);

    // en held high through two runs: exactly two acceptances
    set_perm();
    set_pt(2);
    prep(1'b1);
    model_run();
    model_run();
    @(negedge clk);
    en = 1'b1;
    wait_rdy(1'b0, "hold_run1_busy");
    wait_rdy(1'b1, "hold_run1_done");
    wait_rdy(1'b0, "hold_run2_busy");
    wait_rdy(1'b1, "hold_run2_done");
    en = 1'b0;
    repeat (10) @(negedge clk);
    chk_eq("hold_idle_after", int'(rdy), 1);
    compare_all("hold", 2, 6, 8);

    // random S and messages, first one at full length
    for (int r = 0; r < 4; r++) begin
      len = (r == 0) ? 255 : int'($urandom_range(40, 1));
      set_perm();
      set_pt(len);
      prep(1'b1);
      model_run();
      start_and_wait($sformatf("rand%0d", r), len, n);
      compare_all($sformatf("rand%0d", r), len, len + 1, 2 * len);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
